reflex_judge: RTL and testbench
===============================

// Module: reflex_judge
// PURPOSE
//   Game-round judge on the receive side of the clk_3s pacing interface. Every clk_3s
//   edge (rising or falling, one per 1.5 s) opens a new round and lights one target
//   lamp chosen by an LFSR. Presses on the player buttons are judged hit/wrong.
//   wrong_time is returned to the pacing counter, which stops ticking at 3.
// PARAMETERS
//   N_LAMPS    4       lamp/button count; fixed at 4 (one-hot, 2-bit LFSR select)
//   MAX_WRONG  3       wrong_time value that ends the game
//   MAX_ROUNDS 30      rounds per game (= clk_3s edges; 15 full periods)
//   LFSR_SEED  8'hA5   8-bit LFSR reset value; must be nonzero
// PORTS
//   clk         in   1  50 MHz system clock
//   rst         in   1  asynchronous reset, active-high
//   switch      in   1  game enable; 0 = pause (state frozen)
//   clk_3s      in   1  round pacing square wave; asynchronous to this block's logic, synced
//   btn         in   4  player buttons, active-high, one per lamp
//   led         out  4  one-hot target lamp; 0 = no target shown
//   score       out  5  correct hits, saturates at 31
//   wrong_time  out  3  wrong presses + missed rounds, saturates at 7
//   game_over   out  1  high in DONE
// BEHAVIOUR
// - Reset (async, any time incl. mid-round):
//   - state=IDLE; led=0, score=0, wrong_time=0, game_over=0.
//   - round_cnt=0, lfsr=LFSR_SEED.
// - Input sync:
//   - clk_3s and btn each pass a 2-flop synchronizer plus a previous-value register.
//   - tick = sync_clk3 ^ prev_clk3.
//   - press = sync_btn & ~prev_btn (rising edges only).
//   - led updates exactly 3 clk cycles after a clk_3s toggle.
// - LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances once per accepted tick.
//   - The new lamp is led = 1 << lfsr[1:0], computed from the pre-advance value.
// - switch=0: all state, outputs and counters hold; ticks and presses are discarded, not queued.
// - States:
//   - IDLE: on tick -> ARMED; led from LFSR; round_cnt=1.
//   - ARMED (target shown, no judgement yet):
//     - press==led (exactly one correct bit) -> JUDGED; score+1; led=0.
//     - press!=0, otherwise -> JUDGED; wrong_time+1; led=0. Covers wrong bit and multi-bit press.
//     - tick with no press -> miss: wrong_time+1; new round (stay ARMED); led relit.
//   - JUDGED: further presses ignored; on tick -> ARMED, new lamp.
//   - DONE: led=0, game_over=1. Presses and ticks ignored; exits only via rst.
// - Round end: a tick increments round_cnt.
//   - If round_cnt==MAX_ROUNDS before the increment -> DONE instead of a new round.
//   - The final round's miss is still counted.
// - wrong_time reaching MAX_WRONG -> DONE on that same cycle.
//   - This takes precedence over starting a round.
// - Same-cycle press and tick in ARMED:
//   - The press is judged against the current (old) led first.
//   - The tick is then processed as if the state were JUDGED, so no miss is added.
// - score/wrong_time never wrap: hold at 31/7.
// TESTING
//   1. rst=1 pulse mid-round -> all outputs 0 next cycle, async; round_cnt 0.
//   2. switch=1, clk_3s 0->1 -> led one-hot (seed A5: lfsr[1:0]=01 -> led=4'b0010) at +3 clk.
//      btn=0010 -> score=1, led=0.
//   3. Three rounds, pressing a wrong button -> wrong_time 1,2,3; game_over=1 after the third.
//      Further clk_3s edges leave led=0.
//   4. 30 ticks with correct presses -> score=30, wrong_time=0; game_over on the 31st tick.
//      A 31st press has no effect.
//   5. Press btn aligned so press and tick land in the same cycle -> score+1, no wrong_time;
//      new lamp shown.
//   6. switch=0 for 5 clk_3s edges mid-round -> led/score/wrong_time unchanged.
//      switch=1 -> the next edge resumes.

Source files
------------

// File: rtl/reflex_judge.sv
// reflex_judge: game-round judge driven by the clk_3s pacing square wave.
//   Each clk_3s edge opens a round. The lamp is picked by an 8-bit LFSR.
//   Button presses are judged as a hit or as wrong. Misses and wrong presses
//   accumulate in wrong_time. The game ends at MAX_WRONG or after MAX_ROUNDS.
// Ports:
//   clk        : system clock
//   rst        : asynchronous reset, active-high
//   switch     : game enable (0 = pause, all state frozen, events discarded)
//   clk_3s     : round pacing square wave (asynchronous, synchronised here)
//   btn        : player buttons, active-high, one per lamp
//   led        : one-hot target lamp, 0 = no target shown
//   score      : correct hits, saturating
//   wrong_time : wrong presses + missed rounds, saturating
//   game_over  : high once the game has ended
module reflex_judge #(
  parameter int          N_LAMPS    = 4,
  parameter int          MAX_WRONG  = 3,
  parameter int          MAX_ROUNDS = 30,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               switch,
  input  logic               clk_3s,
  input  logic [N_LAMPS-1:0] btn,
  output logic [N_LAMPS-1:0] led,
  output logic [4:0]         score,
  output logic [2:0]         wrong_time,
  output logic               game_over
);

  typedef enum logic [1:0] {IDLE, ARMED, JUDGED, DONE} state_t;

  state_t               state_reg, state_next;
  logic [N_LAMPS-1:0]   led_reg, led_next;
  logic [4:0]           score_reg, score_next;
  logic [2:0]           wrong_reg, wrong_next;
  logic [4:0]           round_cnt_reg, round_cnt_next;
  logic [7:0]           lfsr_reg, lfsr_next;

  // Two-flop synchronisers plus a previous-value stage for edge detection.
  logic                 clk3_meta_reg, clk3_sync_reg, clk3_prev_reg;
  logic [N_LAMPS-1:0]   btn_meta_reg, btn_sync_reg, btn_prev_reg;

  logic                 tick;
  logic [N_LAMPS-1:0]   press;
  logic [N_LAMPS-1:0]   lamp;
  logic [7:0]           lfsr_adv;
  logic [4:0]           score_inc;
  logic [2:0]           wrong_inc;
  logic                 answered;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk3_meta_reg <= 1'b0;
      clk3_sync_reg <= 1'b0;
      clk3_prev_reg <= 1'b0;
      btn_meta_reg  <= '0;
      btn_sync_reg  <= '0;
      btn_prev_reg  <= '0;
    end else begin
      clk3_meta_reg <= clk_3s;
      clk3_sync_reg <= clk3_meta_reg;
      clk3_prev_reg <= clk3_sync_reg;
      btn_meta_reg  <= btn;
      btn_sync_reg  <= btn_meta_reg;
      btn_prev_reg  <= btn_sync_reg;
    end
  end

  // Both clk_3s edges are round boundaries. Buttons count on the rising edge only.
  assign tick  = clk3_sync_reg ^ clk3_prev_reg;
  assign press = btn_sync_reg & ~btn_prev_reg;

  // Lamp for the new round comes from the LFSR value before it advances.
  assign lamp      = N_LAMPS'(1) << lfsr_reg[1:0];
  assign lfsr_adv  = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  assign score_inc = (score_reg == 5'd31) ? score_reg : score_reg + 5'd1;
  assign wrong_inc = (wrong_reg == 3'd7)  ? wrong_reg : wrong_reg + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      led_reg       <= '0;
      score_reg     <= '0;
      wrong_reg     <= '0;
      round_cnt_reg <= '0;
      lfsr_reg      <= LFSR_SEED;
    end else begin
      state_reg     <= state_next;
      led_reg       <= led_next;
      score_reg     <= score_next;
      wrong_reg     <= wrong_next;
      round_cnt_reg <= round_cnt_next;
      lfsr_reg      <= lfsr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    led_next       = led_reg;
    score_next     = score_reg;
    wrong_next     = wrong_reg;
    round_cnt_next = round_cnt_reg;
    lfsr_next      = lfsr_reg;
    answered       = 1'b0;

    // With switch low, nothing moves. Pending ticks and presses are simply lost.
    if (switch) begin
      unique case (state_reg)
        IDLE: begin
          if (tick) begin
            state_next     = ARMED;
            led_next       = lamp;
            lfsr_next      = lfsr_adv;
            round_cnt_next = 5'd1;
          end
        end
        ARMED, JUDGED: begin
          answered = (state_reg == JUDGED);
          // A press is judged against the lamp currently shown.
          // This happens before any same-cycle tick is handled.
          if (state_reg == ARMED && press != '0) begin
            if (press == led_reg) score_next = score_inc;
            else                  wrong_next = wrong_inc;
            answered   = 1'b1;
            state_next = JUDGED;
            led_next   = '0;
          end
          // A round closing with no answer is a miss.
          if (tick && !answered)
            wrong_next = wrong_inc;
          // Hitting the wrong limit ends the game. It overrides starting a new round.
          if (wrong_next >= 3'(MAX_WRONG)) begin
            state_next = DONE;
            led_next   = '0;
          end else if (tick) begin
            if (round_cnt_reg == 5'(MAX_ROUNDS)) begin
              state_next = DONE;
              led_next   = '0;
            end else begin
              state_next     = ARMED;
              led_next       = lamp;
              lfsr_next      = lfsr_adv;
              round_cnt_next = round_cnt_reg + 5'd1;
            end
          end
        end
        default: begin
          // DONE is left only through reset.
        end
      endcase
    end
  end

  assign led        = led_reg;
  assign score      = score_reg;
  assign wrong_time = wrong_reg;
  assign game_over  = (state_reg == DONE);

endmodule

// File: tb/tb_reflex_judge.sv
// tb_reflex_judge: directed scenarios plus randomized play for reflex_judge.
//   The reference model tracks the game as rounds, a target index and counters.
//   It is compared against the DUT outputs on every falling clock edge.
module tb_reflex_judge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       switch = 1'b0;
  logic       clk_3s = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [3:0] led;
  logic [4:0] score;
  logic [2:0] wrong_time;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  reflex_judge dut (
    .clk(clk), .rst(rst), .switch(switch), .clk_3s(clk_3s), .btn(btn),
    .led(led), .score(score), .wrong_time(wrong_time), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_phase;    // 0 waiting for first round, 1 playing, 2 over
  int         m_target;   // lamp index, -1 when no lamp shown
  int         m_round, m_score, m_wrong;
  bit         m_answered;
  logic [7:0] m_lfsr;
  logic       c3h [4];    // clk_3s sampled at the last four rising edges
  logic [3:0] bh  [4];

  function automatic logic [3:0] m_led();
    return (m_target < 0) ? 4'b0 : (4'b0001 << m_target);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_target = -1; m_round = 0; m_score = 0; m_wrong = 0;
    m_answered = 1'b0; m_lfsr = 8'hA5;
    for (int i = 0; i < 4; i++) begin c3h[i] = 1'b0; bh[i] = 4'b0; end
  endtask

  task automatic new_lamp();
    m_target = int'(m_lfsr) % 4;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    m_answered = 1'b0;
  endtask

  task automatic model_step();
    logic       tk;
    logic [3:0] pr;
    for (int i = 3; i > 0; i--) begin c3h[i] = c3h[i-1]; bh[i] = bh[i-1]; end
    c3h[0] = clk_3s; bh[0] = btn;
    // Inputs need two rising edges to cross the synchronizer and one more to be acted on.
    tk = c3h[2] ^ c3h[3];
    pr = bh[2] & ~bh[3];
    if (!switch || m_phase == 2) return;
    if (m_phase == 0) begin
      if (tk) begin m_phase = 1; m_round = 1; new_lamp(); end
      return;
    end
    if (!m_answered && pr != 4'b0) begin
      if (pr == m_led()) m_score = (m_score < 31) ? m_score + 1 : 31;
      else               m_wrong = (m_wrong < 7) ? m_wrong + 1 : 7;
      m_answered = 1'b1;
      m_target = -1;
    end
    if (tk && !m_answered) m_wrong = (m_wrong < 7) ? m_wrong + 1 : 7;
    if (m_wrong >= 3) begin
      m_phase = 2; m_target = -1;
    end else if (tk) begin
      if (m_round >= 30) begin m_phase = 2; m_target = -1; end
      else begin m_round++; new_lamp(); end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model_led", 32'(led), 32'(m_led()));
      chk("model_score", 32'(score), 32'(m_score));
      chk("model_wrong", 32'(wrong_time), 32'(m_wrong));
      chk("model_game_over", 32'(game_over), 32'(m_phase == 2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle3();
    clk_3s = ~clk_3s;
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    cyc(1);
    btn = 4'b0;
    cyc(5);
  endtask

  // Reset is raised between clock edges. The outputs must clear before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; clk_3s = 1'b0; btn = 4'b0;
    #1;
    chk("async_rst_led", 32'(led), 0);
    chk("async_rst_score", 32'(score), 0);
    chk("async_rst_wrong", 32'(wrong_time), 0);
    chk("async_rst_over", 32'(game_over), 0);
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] l;
    cyc(3);
    chk("reset_led", 32'(led), 0);
    chk("reset_score", 32'(score), 0);
    rst = 1'b0;
    cyc(2);

    // First round: lamp from seed A5 appears exactly three cycles after the edge.
    switch = 1'b1;
    toggle3();
    cyc(2);
    chk("lat_led_early", 32'(led), 0);
    cyc(1);
    chk("first_led", 32'(led), 32'(4'b0010));
    press(4'b0010);
    chk("hit_score", 32'(score), 1);
    chk("hit_led_off", 32'(led), 0);

    // Start another round, then reset in the middle of it.
    toggle3();
    cyc(5);
    do_reset();
    cyc(2);

    // Three wrong presses end the game.
    for (int i = 0; i < 3; i++) begin
      toggle3();
      cyc(5);
      l = m_led();
      press({l[2:0], l[3]});
      chk("wrong_count", 32'(wrong_time), 32'(i + 1));
    end
    chk("wrong_game_over", 32'(game_over), 1);
    repeat (2) begin toggle3(); cyc(5); end
    chk("done_led_dark", 32'(led), 0);
    chk("done_still_over", 32'(game_over), 1);

    // Thirty correct rounds, then the 31st edge ends the game.
    do_reset();
    cyc(2);
    for (int r = 0; r < 30; r++) begin
      toggle3();
      cyc(5);
      press(m_led());
    end
    chk("full_score", 32'(score), 30);
    chk("full_wrong", 32'(wrong_time), 0);
    chk("full_not_over", 32'(game_over), 0);
    toggle3();
    cyc(5);
    chk("round_limit_over", 32'(game_over), 1);
    press(4'b0001);
    chk("after_done_press", 32'(score), 30);

    // A press and an edge land in the same cycle.
    do_reset();
    cyc(2);
    toggle3();
    cyc(5);
    chk("same_cyc_led0", 32'(led), 32'(4'b0010));
    btn = 4'b0010;
    toggle3();
    cyc(1);
    btn = 4'b0;
    cyc(5);
    chk("same_cyc_score", 32'(score), 1);
    chk("same_cyc_wrong", 32'(wrong_time), 0);
    chk("same_cyc_new_led", 32'(led), 32'(4'b0100));

    // Pause across five edges. Presses during the pause are discarded too.
    switch = 1'b0;
    repeat (5) begin
      toggle3();
      btn = 4'b0100;
      cyc(1);
      btn = 4'b0;
      cyc(5);
    end
    chk("pause_led", 32'(led), 32'(4'b0100));
    chk("pause_score", 32'(score), 1);
    chk("pause_wrong", 32'(wrong_time), 0);
    switch = 1'b1;
    toggle3();
    cyc(5);
    chk("resume_miss", 32'(wrong_time), 1);
    chk("resume_led", 32'(led), 32'(4'b0010));

    // Randomized games. Each game starts with a reset at a random point in play.
    for (int g = 0; g < 25; g++) begin
      do_reset();
      switch = 1'b1;
      for (int c = 0; c < 700; c++) begin
        int r;
        if ($urandom_range(0, 11) == 0) toggle3();
        r = int'($urandom_range(0, 59));
        if (r == 0)      btn = 4'($urandom_range(0, 15));
        else if (r < 7)  btn = m_led();
        else             btn = 4'b0;
        if ($urandom_range(0, 79) == 0) switch = ~switch;
        cyc(1);
      end
    end

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
